// File: rtl/pwm_bank_if.sv
// pwm_bank_if -- control/status bundle for the pwm_bank PWM generator.
//
//   en_out  [NCH]      per-channel output enable (0 forces the output low)
//   en_pwm  [NCH]      per-channel mode: 1 = PWM, 0 = static high
//   duty    [NCH][RES] per-channel duty; packed so channel k sits at [k*RES +: RES]
//   period  [RES]      counter terminal value (TOP)
//   presc   [PW]       prescaler divide value, tick rate = clk/(presc+1)
//   center             0 = edge-aligned, 1 = centre-aligned
//   update             one-cycle strobe capturing duty/period/center into shadows
//   out     [NCH]      registered PWM outputs
//   cyc_end            one-cycle pulse after each period boundary
//   busy               shadow load pending
//
// master drives the controls, slave is the PWM bank.
interface pwm_bank_if #(
  parameter int NCH = 16,
  parameter int RES = 8,
  parameter int PW  = 8
);
  logic [NCH-1:0]          en_out;
  logic [NCH-1:0]          en_pwm;
  logic [NCH-1:0][RES-1:0] duty;
  logic [RES-1:0]          period;
  logic [PW-1:0]           presc;
  logic                    center;
  logic                    update;
  logic [NCH-1:0]          out;
  logic                    cyc_end;
  logic                    busy;

  modport master (
    output en_out, en_pwm, duty, period, presc, center, update,
    input  out, cyc_end, busy
  );

  modport slave (
    input  en_out, en_pwm, duty, period, presc, center, update,
    output out, cyc_end, busy
  );
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank -- bank of NCH PWM channels sharing one prescaler and one counter.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  pwm_bank_if.slave: enables, duty/period/center/presc controls,
//        update strobe in; out, cyc_end, busy status out.
//
// duty/period/center are double-buffered: update writes the shadow set and
// the active set takes it at the next period boundary so a running period is
// never cut short. A load restarts the counter at 0 counting up. en_out,
// en_pwm and presc are used live.
module pwm_bank #(
  parameter int NCH = 16,
  parameter int RES = 8,
  parameter int PW  = 8
) (
  input  logic      clk,
  input  logic      rst,
  pwm_bank_if.slave bus
);

  typedef logic [RES-1:0] cnt_t;

  // prescaler / counter
  logic [PW-1:0] presc_q, presc_d;
  cnt_t          cnt_q, cnt_d;
  logic          down_q, down_d;

  // shadow and active parameter sets
  logic [NCH-1:0][RES-1:0] duty_sh_q, duty_sh_d;
  logic [NCH-1:0][RES-1:0] duty_act_q, duty_act_d;
  cnt_t                    period_sh_q, period_sh_d;
  cnt_t                    period_act_q, period_act_d;
  logic                    center_sh_q, center_sh_d;
  logic                    center_act_q, center_act_d;

  // status / outputs
  logic           busy_q, busy_d;
  logic           cyc_end_q, cyc_end_d;
  logic [NCH-1:0] out_q, out_d;

  logic tick;
  logic bnd;       // current cnt is the last one of the period
  cnt_t cnt_nxt;
  logic down_nxt;

  // >= rather than == so a presc lowered below the running count still
  // produces a tick on the next cycle instead of waiting for a wrap.
  assign tick = (presc_q >= bus.presc);

  // Counter step, applied only on tick.
  always_comb begin
    cnt_nxt  = cnt_q;
    down_nxt = down_q;
    bnd      = 1'b0;
    if (period_act_q == '0) begin
      // TOP=0: pinned at 0 in either mode, every tick is a boundary
      cnt_nxt  = '0;
      down_nxt = 1'b0;
      bnd      = 1'b1;
    end else if (!center_act_q) begin
      bnd      = (cnt_q >= period_act_q);
      cnt_nxt  = bnd ? '0 : cnt_q + 1'b1;
      down_nxt = 1'b0;
    end else if (!down_q && (cnt_q < period_act_q)) begin
      cnt_nxt = cnt_q + 1'b1;
    end else begin
      // Turning at TOP goes straight to TOP-1 so TOP is held for one tick;
      // the 1->0 step closes the period and 0 is then visited only once
      // because the counter turns up immediately.
      cnt_nxt  = down_q ? cnt_q - 1'b1 : period_act_q - 1'b1;
      bnd      = (cnt_nxt == '0);
      down_nxt = !bnd;
    end
  end

  always_comb begin
    presc_d      = tick ? '0 : presc_q + 1'b1;
    cnt_d        = tick ? cnt_nxt : cnt_q;
    down_d       = tick ? down_nxt : down_q;
    cyc_end_d    = tick & bnd;
    duty_sh_d    = duty_sh_q;
    period_sh_d  = period_sh_q;
    center_sh_d  = center_sh_q;
    duty_act_d   = duty_act_q;
    period_act_d = period_act_q;
    center_act_d = center_act_q;
    busy_d       = busy_q;

    if (bus.update) begin
      duty_sh_d   = bus.duty;
      period_sh_d = bus.period;
      center_sh_d = bus.center;
    end

    if (tick && bnd && (busy_q || bus.update)) begin
      // An update landing on the boundary itself bypasses the shadow set.
      duty_act_d   = bus.update ? bus.duty   : duty_sh_q;
      period_act_d = bus.update ? bus.period : period_sh_q;
      center_act_d = bus.update ? bus.center : center_sh_q;
      busy_d       = 1'b0;
    end else if (bus.update) begin
      busy_d = 1'b1;
    end
  end

  // Per-lane output select: enable gates everything, static mode is high.
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    assign out_d[k] = bus.en_out[k] & (~bus.en_pwm[k] | (cnt_q < duty_act_q[k]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      cnt_q        <= '0;
      down_q       <= 1'b0;
      duty_sh_q    <= '0;
      duty_act_q   <= '0;
      period_sh_q  <= '1;
      period_act_q <= '1;
      center_sh_q  <= 1'b0;
      center_act_q <= 1'b0;
      busy_q       <= 1'b0;
      cyc_end_q    <= 1'b0;
      out_q        <= '0;
    end else begin
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      down_q       <= down_d;
      duty_sh_q    <= duty_sh_d;
      duty_act_q   <= duty_act_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      center_sh_q  <= center_sh_d;
      center_act_q <= center_act_d;
      busy_q       <= busy_d;
      cyc_end_q    <= cyc_end_d;
      out_q        <= out_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.cyc_end = cyc_end_q;
  assign bus.busy    = busy_q;

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
Parameters:
REQ-001 NCH, 16, number of PWM channels (1..32).
REQ-002 RES, 8, counter and duty resolution in bits (4..16).
REQ-003 PW, 8, prescaler width in bits.
Ports:
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 en_out  in  NCH  per-channel output enable; 0 forces the output low.
REQ-007 en_pwm  in  NCH  per-channel mode; 1 = PWM, 0 = static high (when en_out=1).
REQ-008 duty  in  NCH*RES  packed duty values; channel k occupies [k*RES +: RES].
REQ-009 period  in  RES  counter terminal value (TOP).
REQ-010 presc  in  PW  prescaler divide value; the tick rate is clk/(presc+1).
REQ-011 center  in  1  0 = edge-aligned (up-count), 1 = centre-aligned (up/down).
REQ-012 update  in  1  one-cycle strobe; samples duty, period and center into shadow registers.
REQ-013 out  out  NCH  registered PWM outputs.
REQ-014 cyc_end  out  1  one-cycle pulse at each period boundary.
REQ-015 busy  out  1  high while a shadow load is pending.

Function
REQ-016 The prescaler counts 0..presc; tick SHALL assert for the one clk cycle in which the prescaler equals presc, and the prescaler then returns to 0; presc=0 gives a tick every cycle.
REQ-017 The main counter cnt SHALL advance only on tick.
REQ-018 Edge mode: cnt SHALL count 0,1,..,TOP,0; the boundary is the tick where cnt=TOP.
REQ-019 Centre mode: cnt SHALL count 0 up to TOP, then down to 0, with the direction reversing at TOP and at 0; the boundary is the tick where cnt=1 while counting down (next value 0); each of TOP and 0 is visited once per cycle.
REQ-020 Edge-mode period is (TOP+1)*(presc+1) clk cycles; centre-mode period is 2*TOP*(presc+1) clk cycles.
REQ-021 update=1 SHALL copy duty, period and center into the shadow registers and set busy.
REQ-022 At a boundary tick with busy=1, the shadow registers SHALL load into the active registers, cnt SHALL restart at 0 counting up, and busy SHALL clear.
REQ-023 If update coincides with a boundary tick, the values presented in that cycle SHALL be the ones loaded at that boundary, and busy SHALL remain 0.
REQ-024 An update while busy=1 SHALL overwrite the shadow registers; only the last value is loaded.
REQ-025 The raw PWM level for channel k SHALL be (cnt < duty_act[k]) as an unsigned RES-bit compare.
REQ-026 duty_act[k]=0 SHALL give a constant low; duty_act[k] > TOP SHALL give a constant high (edge mode gives 100% only for duty >= TOP+1).
REQ-027 out[k] SHALL equal 0 if en_out[k]=0; otherwise 1 if en_pwm[k]=0; otherwise the raw PWM level. out is registered: 1 clk of latency from cnt, en_out and en_pwm.
REQ-028 en_out and en_pwm SHALL act directly, without waiting for a boundary.
REQ-029 cyc_end SHALL be registered, asserting in the clk cycle after each boundary tick.
REQ-030 TOP=0 in edge mode SHALL hold cnt at 0, with a boundary on every tick; TOP=0 in centre mode SHALL behave identically to edge mode with TOP=0.

Reset
REQ-031 While rst=1: out=0, cyc_end=0, busy=0, prescaler=0, cnt=0 counting up, all active and shadow duty values=0, active and shadow period=2^RES-1, center=0.
REQ-032 Reset asserted mid-period SHALL clear all state immediately, regardless of clk; counting SHALL resume from cnt=0 on the first clk edge after rst deasserts.
REQ-033 A pending shadow load SHALL be discarded by reset.

Verification
REQ-034 RES=8, presc=0, period=255, update with duty[0]=64, all enables on -> after the next boundary, out[0] is high for 64 of every 256 cycles, and cyc_end pulses every 256 cycles.
REQ-035 presc=3, period=9, duty=5, edge mode -> 40-cycle period, high for 20 cycles; cyc_end spacing is 40.
REQ-036 Centre mode, presc=0, period=10, duty=4 -> 20-cycle period with a high pulse of 7 cycles (cnt 0..3 down and up) centred on cnt=0.
REQ-037 duty=0 -> out constant 0; duty=200 with period=100 -> out constant 1; en_pwm=0 -> out=1; en_out=0 -> out=0, each within 1 cycle.
REQ-038 update mid-period -> busy=1 and the old duty is kept until the boundary, then the new duty applies; a second update before the boundary -> only the second value takes effect; update on the boundary cycle -> applies immediately with busy=0.
REQ-039 Assert rst mid-period for 1 cycle without a clk edge -> out and cnt are 0 asynchronously, busy=0, and after release period=255 and duty=0.
